// File: rtl/cache_pkg.sv
// cache_pkg: cache geometry, set-info/data types and fill controller state encoding.
package cache_pkg;
   localparam int SetWidth      = 4;
   localparam int TagWidth      = 8;
   localparam int Associativity = 4;
   localparam int WayWidth      = $clog2(Associativity);
   localparam int DataWidth     = 16;
   localparam int MemAddrWidth  = TagWidth + SetWidth;

   typedef struct packed {
      logic                valid;
      logic [TagWidth-1:0] tag;
   } block_info_t;

   typedef block_info_t [Associativity-1:0] set_info_t;
   typedef logic [DataWidth-1:0]            block_data_t;
   typedef logic [MemAddrWidth-1:0]         mem_addr_t;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DONE} fill_state_e;
endpackage

// File: rtl/cache_victim_sel.sv
// cache_victim_sel: tag hit detection and victim choice (first invalid way, else round-robin).
module cache_victim_sel
   import cache_pkg::*;
(
   input  set_info_t           info,
   input  logic [WayWidth-1:0] rr,
   input  logic [TagWidth-1:0] tag,
   output logic                hit,
   output logic [WayWidth-1:0] hit_way,
   output logic [WayWidth-1:0] victim_way,
   output logic                victim_was_valid
);
   // Descending scan so the lowest-index match wins for both hit and free way.
   always_comb begin
      hit = 1'b0;
      hit_way = '0;
      victim_way = rr;
      victim_was_valid = 1'b1;
      for (int i = Associativity - 1; i >= 0; i--) begin
         if (info[i].valid && info[i].tag == tag) begin
            hit = 1'b1;
            hit_way = WayWidth'(i);
         end
         if (!info[i].valid) begin
            victim_way = WayWidth'(i);
            victim_was_valid = 1'b0;
         end
      end
   end
endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: accepts a miss, fetches the block and writes set info/data into the cache.
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int TimeoutCycles = 64
)(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                miss_valid_i,
  output logic                miss_ready_o,
  input  logic [SetWidth-1:0] miss_set_i,
  input  logic [TagWidth-1:0] miss_tag_i,
  input  set_info_t           miss_info_i,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output mem_addr_t           mem_req_addr_o,
  input  logic                mem_resp_valid_i,
  input  block_data_t         mem_resp_data_i,
  output logic                write_en_o,
  output logic [SetWidth-1:0] write_set_o,
  output set_info_t           write_info_o,
  output logic [WayWidth-1:0] write_data_way_o,
  output block_data_t         write_data_o,
  output logic                fill_done_o,
  output logic [WayWidth-1:0] fill_way_o,
  output logic                fill_err_o
);
  fill_state_e         state_q, state_d;
  logic [SetWidth-1:0] set_q;
  logic [TagWidth-1:0] tag_q;
  set_info_t           info_q, info_upd;
  logic [WayWidth-1:0] way_q, rr_q, rr_next, rr_restore;
  block_data_t         data_q;
  logic                hit, victim_was_valid, accept, timeout;
  logic [WayWidth-1:0] hit_way, victim_way;

  cache_victim_sel u_sel (
    .info             (miss_info_i),
    .rr               (rr_q),
    .tag              (miss_tag_i),
    .hit              (hit),
    .hit_way          (hit_way),
    .victim_way       (victim_way),
    .victim_was_valid (victim_was_valid)
  );

  assign accept  = state_q == IDLE && miss_valid_i;
  assign rr_next = rr_q == WayWidth'(Associativity - 1) ? '0 : rr_q + 1'b1;

`ifdef CACHE_FILL_TIMEOUT_EN
  localparam int CntWidth = $clog2(TimeoutCycles + 1);
  logic [CntWidth-1:0] cnt_q;
  logic [WayWidth-1:0] rr_save_q;
  logic                err_q;

  assign timeout    = state_q == WAIT && !mem_resp_valid_i && cnt_q == CntWidth'(TimeoutCycles - 1);
  assign rr_restore = rr_save_q;
  assign fill_err_o = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      rr_save_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= state_q == WAIT ? cnt_q + 1'b1 : '0;
      err_q <= timeout;
      if (accept) rr_save_q <= rr_q;
    end
  end
`else
  assign timeout    = 1'b0;
  assign rr_restore = rr_q;
  assign fill_err_o = 1'b0;
`endif

  always_comb begin
    info_upd = miss_info_i;
    info_upd[victim_way] = '{valid: 1'b1, tag: miss_tag_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q <= '0;
      set_q <= '0;
      tag_q <= '0;
      info_q <= '0;
      way_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        set_q <= miss_set_i;
        tag_q <= miss_tag_i;
        info_q <= info_upd;
        way_q <= hit ? hit_way : victim_way;
      end
      if (timeout) rr_q <= rr_restore;
      else if (accept && !hit && victim_was_valid) rr_q <= rr_next;
      if (state_q == WAIT && mem_resp_valid_i) data_q <= mem_resp_data_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = miss_valid_i ? (hit ? DONE : REQ) : IDLE;
      REQ:     state_d = mem_req_ready_i ? WAIT : REQ;
      WAIT:    state_d = mem_resp_valid_i ? WRITE : (timeout ? IDLE : WAIT);
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    miss_ready_o     = state_q == IDLE;
    mem_req_valid_o  = state_q == REQ;
    mem_req_addr_o   = state_q == REQ ? {tag_q, set_q} : '0;
    write_en_o       = state_q == WRITE;
    write_set_o      = state_q == WRITE ? set_q : '0;
    write_info_o     = state_q == WRITE ? info_q : '0;
    write_data_way_o = state_q == WRITE ? way_q : '0;
    write_data_o     = state_q == WRITE ? data_q : '0;
    fill_done_o      = state_q == DONE;
    fill_way_o       = state_q == DONE ? way_q : '0;
  end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: directed fills with a scoreboard of expected write/done/err events.
module tb_cache_fill_ctrl;
  import cache_pkg::*;

  typedef struct {
    int          kind;
    logic [3:0]  set;
    set_info_t   info;
    logic [1:0]  way;
    block_data_t data;
  } exp_t;

  logic                clk_i = 1'b0, rst_i = 1'b1;
  logic                miss_valid_i = 1'b0, miss_ready_o;
  logic [SetWidth-1:0] miss_set_i = '0;
  logic [TagWidth-1:0] miss_tag_i = '0;
  set_info_t           miss_info_i = '0;
  logic                mem_req_valid_o, mem_req_ready_i = 1'b0;
  mem_addr_t           mem_req_addr_o;
  logic                mem_resp_valid_i = 1'b0;
  block_data_t         mem_resp_data_i = '0;
  logic                write_en_o;
  logic [SetWidth-1:0] write_set_o;
  set_info_t           write_info_o;
  logic [WayWidth-1:0] write_data_way_o, fill_way_o;
  block_data_t         write_data_o;
  logic                fill_done_o, fill_err_o;

  int   total = 0, bad = 0;
  exp_t q[$];
  exp_t me;

  cache_fill_ctrl #(.TimeoutCycles(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
    .miss_set_i(miss_set_i), .miss_tag_i(miss_tag_i), .miss_info_i(miss_info_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i),
    .write_en_o(write_en_o), .write_set_o(write_set_o), .write_info_o(write_info_o),
    .write_data_way_o(write_data_way_o), .write_data_o(write_data_o),
    .fill_done_o(fill_done_o), .fill_way_o(fill_way_o), .fill_err_o(fill_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  function automatic set_info_t mk(input logic [3:0] v, input logic [7:0] t0, t1, t2, t3);
    return {{v[3], t3}, {v[2], t2}, {v[1], t1}, {v[0], t0}};
  endfunction

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (write_en_o || fill_done_o || fill_err_o) begin
        if (q.size() == 0) chk("unexpected_out", {write_en_o, fill_done_o, fill_err_o}, 0);
        else begin
          me = q.pop_front();
          chk("out_kind", {write_en_o, fill_done_o, fill_err_o}, 3'b100 >> me.kind);
          if (me.kind == 0) begin
            chk("write_set", write_set_o, me.set);
            chk("write_info", write_info_o, me.info);
            chk("write_way", write_data_way_o, me.way);
            chk("write_data", write_data_o, me.data);
          end
          if (me.kind == 1) chk("fill_way", fill_way_o, me.way);
        end
      end
      if (!write_en_o) chk("write_bus_idle", {write_set_o, write_info_o, write_data_way_o, write_data_o}, 0);
      if (!fill_done_o) chk("fill_way_idle", fill_way_o, 0);
    end
  end

  task automatic fill(input logic [3:0] s, input logic [7:0] t, input set_info_t inf,
                      input int rdly, input block_data_t d, input logic [1:0] w, input bit dup);
    exp_t e;
    set_info_t ui;
    ui = inf;
    ui[w] = '{valid: 1'b1, tag: t};
    chk("miss_ready_idle", miss_ready_o, 1);
    if (!dup) begin
      e = '{0, s, ui, w, d};
      q.push_back(e);
    end
    e = '{1, s, ui, w, d};
    q.push_back(e);
    miss_valid_i = 1'b1; miss_set_i = s; miss_tag_i = t; miss_info_i = inf;
    @(negedge clk_i);
    miss_valid_i = 1'b0; miss_info_i = '0;
    chk("miss_ready_busy", miss_ready_o, 0);
    if (dup) begin
      chk("dup_no_req", mem_req_valid_o, 0);
      chk("dup_done_lat", fill_done_o, 1);
      @(negedge clk_i);
    end else begin
      chk("req_valid", mem_req_valid_o, 1);
      chk("req_addr", mem_req_addr_o, {t, s});
      for (int i = 0; i < rdly; i++) begin
        @(negedge clk_i);
        chk("req_hold", {mem_req_valid_o, mem_req_addr_o, miss_ready_o}, {1'b1, t, s, 1'b0});
      end
      mem_req_ready_i = 1'b1;
      @(negedge clk_i);
      mem_req_ready_i = 1'b0;
      mem_resp_valid_i = 1'b1; mem_resp_data_i = d;
      @(negedge clk_i);
      mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
      chk("write_lat", write_en_o, 1);
      @(negedge clk_i);
      chk("done_lat", fill_done_o, 1);
      @(negedge clk_i);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    set_info_t full0;
    full0 = mk(4'hF, 8'h50, 8'h51, 8'h52, 8'h53);
    repeat (2) @(negedge clk_i);
    chk("rst_outs", {miss_ready_o, mem_req_valid_o, mem_req_addr_o, write_en_o, fill_done_o, fill_err_o},
        {1'b1, 1'b0, 12'h0, 1'b0, 1'b0, 1'b0});
    rst_i = 1'b0;
    @(negedge clk_i);
    fill(4'd3, 8'h11, '0, 0, 16'hA5A5, 2'd0, 1'b0);
    fill(4'd4, 8'h22, mk(4'h3, 8'h30, 8'h31, 8'h00, 8'h00), 0, 16'h1234, 2'd2, 1'b0);
    fill(4'd0, 8'h60, full0, 0, 16'h0600, 2'd0, 1'b0);
    fill(4'd0, 8'h61, full0, 0, 16'h0601, 2'd1, 1'b0);
    fill(4'd0, 8'h62, full0, 0, 16'h0602, 2'd2, 1'b0);
    fill(4'd0, 8'h63, full0, 0, 16'h0603, 2'd3, 1'b0);
    fill(4'd9, 8'h40, mk(4'hF, 8'h3F, 8'h40, 8'h41, 8'h42), 0, 16'h0, 2'd1, 1'b1);
    fill(4'd0, 8'h64, full0, 0, 16'h0604, 2'd0, 1'b0);
    fill(4'd7, 8'h99, '0, 5, 16'hBEEF, 2'd0, 1'b0);
    miss_valid_i = 1'b1; miss_set_i = 4'd5; miss_tag_i = 8'h77; miss_info_i = full0;
    @(negedge clk_i);
    miss_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    @(negedge clk_i);
    mem_req_ready_i = 1'b0; rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_wait", {miss_ready_o, mem_req_valid_o, write_en_o, fill_done_o}, 4'b1000);
    repeat (3) begin
      @(negedge clk_i);
      chk("rst_no_write", {miss_ready_o, write_en_o, fill_done_o}, 3'b100);
    end
    fill(4'd0, 8'h70, full0, 0, 16'h0700, 2'd0, 1'b0);
`ifdef CACHE_FILL_TIMEOUT_EN
    begin
      exp_t e;
      e = '{2, 4'd0, '0, 2'd0, '0};
      q.push_back(e);
      miss_valid_i = 1'b1; miss_set_i = 4'd0; miss_tag_i = 8'h71; miss_info_i = full0;
      @(negedge clk_i);
      miss_valid_i = 1'b0; mem_req_ready_i = 1'b1;
      @(negedge clk_i);
      mem_req_ready_i = 1'b0;
      for (int n = 1; n < 8; n++) begin
        @(negedge clk_i);
        chk("to_waiting", {miss_ready_o, fill_err_o}, 2'b00);
      end
      @(negedge clk_i);
      chk("to_err", {miss_ready_o, fill_err_o}, 2'b11);
      mem_resp_valid_i = 1'b1; mem_resp_data_i = 16'hDEAD;
      @(negedge clk_i);
      mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
      chk("to_err_pulse", {fill_err_o, write_en_o, miss_ready_o}, 3'b001);
      @(negedge clk_i);
      fill(4'd0, 8'h72, full0, 0, 16'h0702, 2'd1, 1'b0);
    end
`endif
    repeat (3) @(negedge clk_i);
    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
